button_event_decoder: RTL
=========================

Name: button_event_decoder

Overview:
- Input-side counterpart of the LED status path: converts raw active-low push-button pins into clean debounced levels plus a queue of discrete press, release and long-press events.
- Sits between the board button pins and the control logic.
- Control logic consumes events through a valid/ready handshake instead of sampling raw pins each cycle.

Parameters:
- BUTTONS, 5: number of button inputs, 1..8.
- DEBOUNCE_CYCLES, 270000: cycles a synchronized input must stay stable before the debounced level changes (10 ms at 27 MHz).
- LONG_CYCLES, 27000000: cycles a debounced press must be held before a long-press event is emitted (1 s at 27 MHz). Must be greater than DEBOUNCE_CYCLES.
- DEPTH, 4: event queue depth, power of two, 2..16.

Ports:
- clk27m, input, 1: sole clock.
- reset_n, input, 1: asynchronous, active-low reset.
- button, input, BUTTONS: raw pins, 0 = pressed, asynchronous to clk27m.
- level, output, BUTTONS: debounced state, 1 = pressed.
- event_valid, output, 1: queue head valid.
- event_ready, input, 1: consumer accepts head.
- event_type, output, 2: 0 = press, 1 = release, 2 = long; 3 is never produced.
- event_index, output, 3: button number of head event.
- overflow, output, 1: sticky, an event was lost.
- overflow_clear, input, 1: clears overflow.

Behaviour:
- Reset: asynchronous on reset_n low.
  - Synchronizer flops reset to 1; stable raw state resets to 1.
  - level=0, counters=0, pending bits=0, queue empty, event_valid=0, event_type=0, event_index=0, overflow=0.
  - Reset mid-operation discards all queued and pending events.
- Synchronizer: 2 flops per button.
- Debounce, per button:
  - Counter clears whenever the synchronized value equals the stable value.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable value takes the synchronized value and the counter clears.
  - Any bounce back before that clears the counter.
  - A clean raw edge reaches level exactly DEBOUNCE_CYCLES+2 cycles after the first clk27m edge sampling it.
- Level change cycle C:
  - 0->1 sets pending_press.
  - 1->0 sets pending_release.
- Long press, per button:
  - Hold counter clears while level=0 and counts while level=1.
  - When it reaches LONG_CYCLES-1, pending_long is set once and the counter saturates; no repeat.
  - Release before that point: no long event.
- Pending bits: one each for press, release and long per button.
  - If a bit is set by a new event while already 1, the event is lost and overflow is set.
- Scanner: each cycle the queue is not full, it pushes one pending event and clears that bit.
  - Selection: lowest button index first; within a button, press > long > release.
  - Scanner does not push when the queue is full; pending bits hold.
- Queue: synchronous FIFO, DEPTH entries {type, index}.
  - Head is output registered.
  - Event pending at cycle C appears with event_valid=1 at C+2 when the queue is empty.
  - Pop on event_valid & event_ready. event_type/event_index stay stable while valid & !ready.
  - Simultaneous push and pop when full is allowed, occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- overflow: set has priority over overflow_clear in the same cycle.
- Widths: debounce counter $clog2(DEBOUNCE_CYCLES); hold counter $clog2(LONG_CYCLES); no truncation permitted.

Test Plan (BUTTONS=5, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, DEPTH=4):
- Reset: hold reset_n=0 with button=5'b00000 -> level=0, event_valid=0, overflow=0 throughout reset. After release, level[4:0]=5'b11111 after 6 cycles.
- Clean press: button[2] 1->0 held, event_ready=1 -> level[2]=1 at edge 6; one event type=0 index=2 with event_valid high for one cycle at edge 8. Release -> type=1 index=2.
- Bounce: button[1] toggles every 2 cycles for 20 cycles then stays 1 -> level[1] never changes, no events.
- Long press: hold button[0] low 40 cycles -> events press(0), then long(0) once ~20 cycles after level rose, then release(0) after button returns to 1. Exactly 3 events.
- Simultaneous events with event_ready=0: press button[3] and button[1] in the same cycle -> queue holds index 1 then index 3. Raise ready -> popped in that order; data stable while stalled.
- Overflow: event_ready=0, generate more than 4 events so a pending bit is re-set -> overflow=1, queue full with 4 oldest events. Pulse overflow_clear -> overflow=0; overflow_clear in the same cycle as a new loss -> overflow stays 1.

Source files
------------

// File: rtl/button_event_decoder.sv
// Push-button front end: synchronizes and debounces active-low pins, then turns
// level changes and long holds into a small queue of {type, index} events.
module button_event_decoder #(
  parameter int BUTTONS         = 5,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 27000000,
  parameter int DEPTH           = 4
) (
  input  logic               clk27m,
  input  logic               reset_n,
  input  logic [BUTTONS-1:0] button,
  output logic [BUTTONS-1:0] level,
  output logic               event_valid,
  input  logic               event_ready,
  output logic [1:0]         event_type,
  output logic [2:0]         event_index,
  output logic               overflow,
  input  logic               overflow_clear
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 2);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;

  logic [BUTTONS-1:0] sync1, sync2, stable;
  logic [DW-1:0]      db_cnt   [BUTTONS];
  logic [HW-1:0]      hold_cnt [BUTTONS];

  logic [BUTTONS-1:0] rise, fall, long_hit;
  logic [BUTTONS-1:0] pend_p, pend_r, pend_l;
  logic [BUTTONS-1:0] clr_p, clr_r, clr_l;
  logic               lost;

  logic               push, pop, load, full;
  logic [1:0]         push_type;
  logic [2:0]         push_index;
  logic [4:0]         mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        mem_cnt, occupancy;

  // Synchronizers idle high so a released pin after reset produces no event.
  always_ff @(posedge clk27m or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk27m or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '1;
      for (int i = 0; i < BUTTONS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < BUTTONS; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign rise = ~stable & ~level;
  assign fall = stable & level;

  always_comb begin
    long_hit = '0;
    for (int i = 0; i < BUTTONS; i++)
      long_hit[i] = level[i] && (hold_cnt[i] == HOLD_FIRE);
  end

  // Hold counter parks at its last value so a long hold fires exactly once.
  always_ff @(posedge clk27m or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
      for (int i = 0; i < BUTTONS; i++) hold_cnt[i] <= '0;
    end else begin
      level <= ~stable;
      for (int i = 0; i < BUTTONS; i++) begin
        if (!level[i])
          hold_cnt[i] <= '0;
        else if (hold_cnt[i] != HOLD_LAST)
          hold_cnt[i] <= hold_cnt[i] + HW'(1);
      end
    end
  end

  // Lowest button wins; within a button press, then long, then release.
  always_comb begin
    clr_p      = '0;
    clr_r      = '0;
    clr_l      = '0;
    push       = 1'b0;
    push_type  = EV_PRESS;
    push_index = 3'd0;
    if (!full || pop) begin
      for (int i = 0; i < BUTTONS; i++) begin
        if (!push) begin
          if (pend_p[i]) begin
            push = 1'b1; push_type = EV_PRESS; push_index = 3'(i); clr_p[i] = 1'b1;
          end else if (pend_l[i]) begin
            push = 1'b1; push_type = EV_LONG; push_index = 3'(i); clr_l[i] = 1'b1;
          end else if (pend_r[i]) begin
            push = 1'b1; push_type = EV_RELEASE; push_index = 3'(i); clr_r[i] = 1'b1;
          end
        end
      end
    end
  end

  // A bit being drained this cycle can take a fresh event without a loss.
  assign lost = |((rise & pend_p & ~clr_p) |
                  (fall & pend_r & ~clr_r) |
                  (long_hit & pend_l & ~clr_l));

  always_ff @(posedge clk27m or negedge reset_n) begin
    if (!reset_n) begin
      pend_p   <= '0;
      pend_r   <= '0;
      pend_l   <= '0;
      overflow <= 1'b0;
    end else begin
      pend_p <= (pend_p & ~clr_p) | rise;
      pend_r <= (pend_r & ~clr_r) | fall;
      pend_l <= (pend_l & ~clr_l) | long_hit;
      if (lost)
        overflow <= 1'b1;
      else if (overflow_clear)
        overflow <= 1'b0;
    end
  end

  // Occupancy counts storage plus the registered head slot.
  assign pop       = event_valid & event_ready;
  assign occupancy = mem_cnt + {{AW{1'b0}}, event_valid};
  assign full      = (occupancy == DEPTH_CNT);
  assign load      = (!event_valid || pop) && (mem_cnt != '0);

  always_ff @(posedge clk27m) begin
    if (push) mem[wr_ptr] <= {push_type, push_index};
  end

  always_ff @(posedge clk27m or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      event_valid <= 1'b0;
      event_type  <= 2'd0;
      event_index <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) begin
        {event_type, event_index} <= mem[rd_ptr];
        rd_ptr                    <= rd_ptr + AW'(1);
        event_valid               <= 1'b1;
      end else if (pop) begin
        event_valid <= 1'b0;
      end
      mem_cnt <= mem_cnt + (AW+1)'(push) - (AW+1)'(load);
    end
  end

endmodule
